// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared states and constants for the memory loaders
package instr_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam int WORD_BYTES    = 4;
  localparam int DEFAULT_DEPTH = 32;
  localparam int ADDR_SHIFT    = 2;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs four bytes big-endian into a 32-bit word
// word_ready_o flags the shift that completes a word; word_o is valid the cycle after.
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        shift_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_word <= 32'd0;
      r_cnt  <= 2'd0;
    end else if (shift_en_i) begin
      r_word <= {r_word[23:0], byte_i};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  assign word_o       = r_word;
  assign word_ready_o = shift_en_i && (r_cnt == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream writer for the instruction memory
// Optional trailer XOR check enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LEN_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_word_cnt;
  logic             r_err;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  logic             w_len_ok;
  logic             w_start_ok;
  logic             w_shift;
  logic             w_word_ready;
  logic [31:0]      w_word;
  logic [31:0]      w_addr;
  logic [LEN_W-1:0] w_cnt_next;
  logic             w_last;

  assign w_len_ok   = (len_i != '0) && (len_i <= DEPTH_L);
  assign w_start_ok = start_i && (r_state == S_IDLE) && w_len_ok;
  assign w_shift    = byte_valid_i && (r_state == S_RECV);
  assign w_addr     = 32'(r_word_cnt) << ADDR_SHIFT;
  assign w_cnt_next = r_word_cnt + LEN_W'(1);
  assign w_last     = (w_cnt_next == r_len);

  byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (w_start_ok),
    .shift_en_i   (w_shift),
    .byte_i       (byte_i),
    .word_o       (w_word),
    .word_ready_o (w_word_ready)
  );

  always_comb begin
    w_next       = r_state;
    byte_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_next = w_len_ok ? S_RECV : S_ERR;
      end
      S_RECV: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (w_word_ready) w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we_o = 1'b1;
        busy_o   = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (w_last) w_next = S_CHK;
`else
        if (w_last) w_next = S_DONE;
`endif
        else w_next = S_RECV;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address/data show the live word during WRITE and hold the last written word otherwise.
  assign mem_addr_o  = (r_state == S_WRITE) ? w_addr : r_addr;
  assign mem_wdata_o = (r_state == S_WRITE) ? w_word : r_wdata;
  assign err_o       = r_err;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] r_xor;

  always_ff @(posedge clk_i) begin
    if (rst_i || w_start_ok) begin
      r_xor <= 8'd0;
    end else if (w_shift) begin
      r_xor <= r_xor ^ byte_i;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_err      <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
    end else begin
      r_state <= w_next;
      if (start_i && (r_state == S_IDLE)) begin
        if (w_len_ok) begin
          r_len      <= len_i;
          r_word_cnt <= '0;
          r_err      <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (r_state == S_WRITE) begin
        r_word_cnt <= w_cnt_next;
        r_addr     <= w_addr;
        r_wdata    <= w_word;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      if ((r_state == S_CHK) && byte_valid_i && (byte_i != r_xor)) r_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader
// Honours INSTR_LOADER_CHECKSUM_EN by sending the trailer byte.
module tb_instr_mem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  len_i = 6'd0;
  logic [7:0]  byte_i = 8'd0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  instr_mem_loader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .len_i        (len_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] mon_a, mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every write must match the oldest expected word.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_o) done_cnt++;
      if (mem_we_o) begin
        last_addr = mem_addr_o;
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write actual=%h/%h required=none", mem_addr_o, mem_wdata_o);
        end else begin
          mon_a = exp_addr_q.pop_front();
          mon_d = exp_data_q.pop_front();
          check("write_addr", mem_addr_o, mon_a);
          check("write_data", mem_wdata_o, mon_d);
        end
      end
    end
  end

  // Reference model: word k is bytes 4k..4k+3, first byte most significant, at address 4k.
  task automatic push_expected(input logic [7:0] b[$], input int nwords);
    for (int k = 0; k < nwords; k++) begin
      exp_addr_q.push_back(32'(4 * k));
      exp_data_q.push_back({b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]});
    end
  endtask

  // gap: 0 back-to-back, 1 valid every other cycle, 2 random
  task automatic send(input logic [7:0] b[$], input int gap);
    int  i = 0;
    int  cyc = 0;
    bit  ph = 1'b1;
    bit  v;
    bit  fire;
    while (i < b.size() && cyc < 2000) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? ph : 1'($urandom_range(0, 1));
      ph = ~ph;
      byte_valid_i = v;
      byte_i = v ? b[i] : 8'($urandom);
      @(negedge clk_i);
      fire = byte_valid_i && byte_ready_o;
      @(posedge clk_i);
      #1;
      if (fire) i++;
      cyc++;
    end
    byte_valid_i = 1'b0;
    check("send_bytes_accepted", 32'(i), 32'(b.size()));
  endtask

  task automatic do_load(input int len, input logic [7:0] b[$], input int gap,
                         input bit bad_trailer, input logic exp_err);
    int         d0 = done_cnt;
    int         cyc = 0;
    logic [7:0] t;
    logic [7:0] tq[$];
    push_expected(b, len);
    start_i = 1'b1;
    len_i = 6'(len);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("busy_after_start", 32'(busy_o), 32'd1);
    check("err_after_start", 32'(err_o), 32'd0);
    @(posedge clk_i);
    #1;
    send(b, gap);
`ifdef INSTR_LOADER_CHECKSUM_EN
    t = 8'd0;
    foreach (b[i]) t = t ^ b[i];
    if (bad_trailer) t = t ^ 8'($urandom_range(1, 255));
    tq = '{t};
    send(tq, gap);
`else
    t = 8'(bad_trailer);
    tq = '{t};
`endif
    while (done_cnt == d0 && cyc < 50) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("err_after_load", 32'(err_o), 32'(exp_err));
    check("busy_after_load", 32'(busy_o), 32'd0);
    check("writes_drained", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic bad_start(input int len);
    start_i = 1'b1;
    len_i = 6'(len);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("bad_len_err", 32'(err_o), 32'd1);
    check("bad_len_busy", 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check("bad_len_idle_busy", 32'(busy_o), 32'd0);
    check("bad_len_err_sticky", 32'(err_o), 32'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready_o), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_addr"}, mem_addr_o, 32'd0);
    check({tag, "_wdata"}, mem_wdata_o, 32'd0);
  endtask

  function automatic void rand_bytes(output logic [7:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endfunction

  initial begin
    logic [7:0] b[$];
    logic [7:0] b6[$];
    int         len;

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i);
    #1;

    b = '{8'h00, 8'h22, 8'h08, 8'h20, 8'h8C, 8'h01, 8'h00, 8'h04};
    do_load(2, b, 0, 1'b0, 1'b0);
    do_load(2, b, 1, 1'b0, 1'b0);

    bad_start(0);
    bad_start(33);
    rand_bytes(b, 4);
    do_load(1, b, 2, 1'b0, 1'b0);

    // Reset after six bytes of a three-word load: only word 0 reaches memory.
    rand_bytes(b, 12);
    push_expected(b, 1);
    start_i = 1'b1;
    len_i = 6'd3;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    b6 = b[0:5];
    send(b6, 0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check_reset_outputs("midload_reset");
    check("midload_writes", 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    rand_bytes(b, 4);
    do_load(1, b, 0, 1'b0, 1'b0);

    b = {};
    for (int k = 0; k < 32; k++) begin
      b.push_back(8'h00);
      b.push_back(8'h00);
      b.push_back(8'h00);
      b.push_back(8'(k));
    end
    do_load(32, b, 2, 1'b0, 1'b0);
    check("full_last_addr", last_addr, 32'd124);

    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 8);
      rand_bytes(b, 4 * len);
      do_load(len, b, $urandom_range(0, 2), 1'b0, 1'b0);
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    b = '{8'h00, 8'h22, 8'h08, 8'h20, 8'h8C, 8'h01, 8'h00, 8'h04};
    do_load(2, b, 0, 1'b1, 1'b1);
    do_load(2, b, 1, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
